// File: rtl/spi_flash_arbiter_pkg.sv
// Shared types and helpers for the SPI config-flash arbiter.
`timescale 1ns/1ps
package spi_arb_pkg;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    IDLE_ESP  = 2'd0,
    GUARD_IN  = 2'd1,
    INT       = 2'd2,
    GUARD_OUT = 2'd3
  } arb_state_t;

  // Values reported on the owner output
  localparam logic [1:0] OWNER_ESP   = 2'b00;
  localparam logic [1:0] OWNER_GUARD = 2'b01;
  localparam logic [1:0] OWNER_INT   = 2'b10;

  // Width of a counter that must reach n-1 (at least one bit)
  function automatic int unsigned guard_cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Pin bundle between the arbiter, the ESP passthrough, the internal master and the flash.
`timescale 1ns/1ps
interface spi_flash_arbiter_if;
  // ESP32 passthrough side
  logic       esp_clk;
  logic       esp_mosi;
  logic       esp_cs_n;
  logic       esp_miso;
  // Internal SPI master side
  logic       int_req;
  logic       int_gnt;
  logic       int_clk;
  logic       int_cs_n;
  logic       int_mosi;
  logic       int_miso;
  logic       int_abort;
  // Flash pins
  logic       spiflash_clk;
  logic       spiflash_cs_n;
  logic       spiflash_mosi;
  logic       spiflash_miso;
  // Status / control
  logic [1:0] owner;
  logic       collision_clr;
  logic       esp_collision;

  // Arbiter view
  modport slave (
    input  esp_clk, esp_mosi, esp_cs_n,
    input  int_req, int_clk, int_cs_n, int_mosi,
    input  spiflash_miso, collision_clr,
    output esp_miso, int_gnt, int_miso, int_abort,
    output spiflash_clk, spiflash_cs_n, spiflash_mosi,
    output owner, esp_collision
  );

  // Environment view (ESP, internal master, flash model)
  modport master (
    output esp_clk, esp_mosi, esp_cs_n,
    output int_req, int_clk, int_cs_n, int_mosi,
    output spiflash_miso, collision_clr,
    input  esp_miso, int_gnt, int_miso, int_abort,
    input  spiflash_clk, spiflash_cs_n, spiflash_mosi,
    input  owner, esp_collision
  );
endinterface

// File: rtl/spi_flash_arbiter_sync.sv
// Multi-flop synchronizer for a single asynchronous level (cdc_sync_ff).
`timescale 1ns/1ps
module cdc_sync_ff #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  // Shift the async level through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= {STAGES{RST_VAL}};
    end else begin
      r_q <= {r_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates the SPI config flash between the ESP32 passthrough (default owner, zero
// latency) and the internal SPI master (guarded, collision-checked handover).
// Optional feature macro: SPI_ARB_INT_TIMEOUT_EN -- limits internal ownership to
// INT_MAX_CYCLES and pulses int_abort on a forced revoke.
`timescale 1ns/1ps
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned CLOCK_MHZ      = 27,
  parameter int unsigned GUARD_CYCLES   = CLOCK_MHZ,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned INT_MAX_CYCLES = CLOCK_MHZ * 100000
) (
  input  logic            clk,
  input  logic            rst,
  spi_flash_arbiter_if.slave bus
);

  localparam int unsigned   CNT_W      = guard_cnt_w(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  // Reject configurations the handover logic cannot honour
  if (SYNC_STAGES < 2 || GUARD_CYCLES == 0 || INT_MAX_CYCLES == 0) begin : g_bad_cfg
    $error("spi_flash_arbiter: illegal parameter combination");
  end

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_int_gnt;
  logic [1:0]       r_owner;
  logic             r_collision;
  logic             r_abort;

  logic w_esp_cs_s;
  logic w_esp_act;
  logic w_req_ok;
  logic w_timeout;
  logic w_col_set;

  // Bring ESP chip select into the clk domain
  cdc_sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.esp_cs_n),
    .o_q (w_esp_cs_s)
  );

  assign w_esp_act = ~w_esp_cs_s;

`ifdef SPI_ARB_INT_TIMEOUT_EN
  localparam int unsigned OWN_W = 32;

  logic [OWN_W-1:0] r_own_cnt;
  logic             r_req_blk;

  assign w_timeout = (r_state == INT) && (r_own_cnt == OWN_W'(INT_MAX_CYCLES - 1));
  assign w_req_ok  = bus.int_req && !r_req_blk;

  // Ownership timer; a revoke blocks re-arbitration until int_req has dropped once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own_cnt <= '0;
      r_req_blk <= 1'b0;
    end else begin
      r_own_cnt <= (r_state == INT) ? r_own_cnt + OWN_W'(1) : '0;
      if (w_timeout) begin
        r_req_blk <= 1'b1;
      end else if (!bus.int_req) begin
        r_req_blk <= 1'b0;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_req_ok  = bus.int_req;
`endif

  // ESP activity while it is locked out (INT, GUARD_OUT) is a collision
  assign w_col_set = w_esp_act && ((r_state == INT) || (r_state == GUARD_OUT));

  // Arbitration FSM with registered grant, owner, collision flag and abort pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE_ESP;
      r_cnt       <= '0;
      r_int_gnt   <= 1'b0;
      r_owner     <= OWNER_ESP;
      r_collision <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_abort <= 1'b0;

      if (w_col_set) begin
        r_collision <= 1'b1;
      end else if (bus.collision_clr) begin
        r_collision <= 1'b0;
      end

      case (r_state)
        IDLE_ESP: begin
          r_cnt <= '0;
          if (w_req_ok && !w_esp_act) begin
            r_state <= GUARD_IN;
          end
        end

        GUARD_IN: begin
          if (w_esp_act) begin
            r_state <= IDLE_ESP;
            r_cnt   <= '0;
          end else if (r_cnt == GUARD_LAST) begin
            r_state   <= INT;
            r_cnt     <= '0;
            r_int_gnt <= 1'b1;
            r_owner   <= OWNER_INT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        INT: begin
          r_cnt <= '0;
          if (!bus.int_req || w_timeout) begin
            r_state   <= GUARD_OUT;
            r_int_gnt <= 1'b0;
            r_owner   <= OWNER_GUARD;
            r_abort   <= bus.int_req && w_timeout;
          end
        end

        GUARD_OUT: begin
          if (r_cnt == GUARD_LAST) begin
            r_state <= IDLE_ESP;
            r_cnt   <= '0;
            r_owner <= OWNER_ESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= IDLE_ESP;
          r_cnt     <= '0;
          r_int_gnt <= 1'b0;
          r_owner   <= OWNER_ESP;
        end
      endcase
    end
  end

  logic w_flash_clk;
  logic w_flash_cs_n;
  logic w_flash_mosi;
  logic w_esp_miso;

  // Combinational pin mux steered only by the registered owner
  always_comb begin
    w_flash_clk  = bus.esp_clk;
    w_flash_cs_n = bus.esp_cs_n;
    w_flash_mosi = bus.esp_mosi;
    w_esp_miso   = bus.spiflash_miso;
    case (r_owner)
      OWNER_INT: begin
        w_flash_clk  = bus.int_clk;
        w_flash_cs_n = bus.int_cs_n;
        w_flash_mosi = bus.int_mosi;
        w_esp_miso   = 1'b1;
      end
      OWNER_GUARD: begin
        w_flash_clk  = 1'b0;
        w_flash_cs_n = 1'b1;
        w_flash_mosi = 1'b0;
        w_esp_miso   = 1'b1;
      end
      default: begin
        w_flash_clk  = bus.esp_clk;
        w_flash_cs_n = bus.esp_cs_n;
        w_flash_mosi = bus.esp_mosi;
        w_esp_miso   = bus.spiflash_miso;
      end
    endcase
  end

  assign bus.spiflash_clk  = w_flash_clk;
  assign bus.spiflash_cs_n = w_flash_cs_n;
  assign bus.spiflash_mosi = w_flash_mosi;
  assign bus.esp_miso      = w_esp_miso;
  assign bus.int_miso      = r_int_gnt ? bus.spiflash_miso : 1'b1;
  assign bus.int_gnt       = r_int_gnt;
  assign bus.owner         = r_owner;
  assign bus.esp_collision = r_collision;
  assign bus.int_abort     = r_abort;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed self-checking bench for spi_flash_arbiter (timeout scenario only when
// SPI_ARB_INT_TIMEOUT_EN is defined).
`timescale 1ns/1ps
module tb_spi_flash_arbiter;

  localparam int unsigned GUARD = 27;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned TMAX  = 100;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  spi_flash_arbiter_if u_if();

  spi_flash_arbiter #(
    .CLOCK_MHZ      (27),
    .GUARD_CYCLES   (GUARD),
    .SYNC_STAGES    (SYNC),
    .INT_MAX_CYCLES (TMAX)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    n_checks = 0;
    n_errors = 0;
    pat      = 8'h9F;

    u_if.esp_clk       = 1'b0;
    u_if.esp_mosi      = 1'b0;
    u_if.esp_cs_n      = 1'b1;
    u_if.int_req       = 1'b0;
    u_if.int_clk       = 1'b0;
    u_if.int_cs_n      = 1'b1;
    u_if.int_mosi      = 1'b0;
    u_if.spiflash_miso = 1'b0;
    u_if.collision_clr = 1'b0;

    rst = 1'b1;
    tick(3);
    check_eq("rst_owner", 32'(u_if.owner), 32'd0);
    check_eq("rst_gnt", 32'(u_if.int_gnt), 32'd0);
    check_eq("rst_col", 32'(u_if.esp_collision), 32'd0);
    check_eq("rst_abort", 32'(u_if.int_abort), 32'd0);
    rst = 1'b0;
    tick(3);

    // 1: ESP passthrough with zero delay
    u_if.esp_cs_n = 1'b0;
    #1;
    check_eq("pt_cs", 32'(u_if.spiflash_cs_n), 32'd0);
    for (int i = 7; i >= 0; i--) begin
      u_if.esp_mosi = pat[i];
      #2;
      u_if.esp_clk = 1'b1;
      #1;
      check_eq("pt_clk_hi", 32'(u_if.spiflash_clk), 32'd1);
      check_eq("pt_mosi", 32'(u_if.spiflash_mosi), 32'(pat[i]));
      u_if.spiflash_miso = pat[i];
      #1;
      check_eq("pt_miso", 32'(u_if.esp_miso), 32'(pat[i]));
      u_if.esp_clk = 1'b0;
      #1;
      check_eq("pt_clk_lo", 32'(u_if.spiflash_clk), 32'd0);
    end
    check_eq("pt_owner", 32'(u_if.owner), 32'd0);
    check_eq("pt_gnt", 32'(u_if.int_gnt), 32'd0);
    check_eq("pt_int_miso", 32'(u_if.int_miso), 32'd1);
    u_if.esp_cs_n = 1'b1;
    tick(4);

    // 2: request with ESP idle -> grant GUARD+1 edges later
    u_if.int_req = 1'b1;
    tick(GUARD);
    check_eq("gnt_early", 32'(u_if.int_gnt), 32'd0);
    tick(1);
    check_eq("gnt_on", 32'(u_if.int_gnt), 32'd1);
    check_eq("gnt_owner", 32'(u_if.owner), 32'd2);
    u_if.int_cs_n = 1'b0;
    u_if.int_clk  = 1'b1;
    u_if.int_mosi = 1'b1;
    #1;
    check_eq("int_cs", 32'(u_if.spiflash_cs_n), 32'd0);
    check_eq("int_clk", 32'(u_if.spiflash_clk), 32'd1);
    check_eq("int_mosi", 32'(u_if.spiflash_mosi), 32'd1);
    u_if.spiflash_miso = 1'b1;
    #1;
    check_eq("int_miso_1", 32'(u_if.int_miso), 32'd1);
    u_if.spiflash_miso = 1'b0;
    #1;
    check_eq("int_miso_0", 32'(u_if.int_miso), 32'd0);
    check_eq("int_esp_miso", 32'(u_if.esp_miso), 32'd1);

    // 4: ESP CS during INT -> sticky collision, pins unaffected
    tick(1);
    u_if.esp_cs_n = 1'b0;
    tick(5);
    check_eq("col_set", 32'(u_if.esp_collision), 32'd1);
    check_eq("col_cs_held", 32'(u_if.spiflash_cs_n), 32'd0);
    check_eq("col_mosi_held", 32'(u_if.spiflash_mosi), 32'd1);
    check_eq("col_owner", 32'(u_if.owner), 32'd2);
    u_if.esp_cs_n = 1'b1;
    tick(4);
    check_eq("col_sticky", 32'(u_if.esp_collision), 32'd1);
    u_if.collision_clr = 1'b1;
    tick(1);
    u_if.collision_clr = 1'b0;
    check_eq("col_clr", 32'(u_if.esp_collision), 32'd0);

    // 5: release -> grant drops next edge, forced idle pins for GUARD cycles
    u_if.int_req = 1'b0;
    tick(1);
    check_eq("rel_gnt", 32'(u_if.int_gnt), 32'd0);
    check_eq("rel_owner", 32'(u_if.owner), 32'd1);
    check_eq("rel_clk", 32'(u_if.spiflash_clk), 32'd0);
    check_eq("rel_mosi", 32'(u_if.spiflash_mosi), 32'd0);
    check_eq("rel_int_miso", 32'(u_if.int_miso), 32'd1);
    for (int k = 2; k <= int'(GUARD); k++) begin
      tick(1);
      check_eq("gout_cs", 32'({u_if.owner, u_if.spiflash_cs_n}), 32'b011);
    end
    tick(1);
    check_eq("gout_done", 32'(u_if.owner), 32'd0);
    check_eq("gout_abort", 32'(u_if.int_abort), 32'd0);
    u_if.int_cs_n = 1'b1;
    u_if.int_clk  = 1'b0;
    u_if.int_mosi = 1'b0;
    u_if.esp_cs_n = 1'b0;
    #1;
    check_eq("back_pt_cs", 32'(u_if.spiflash_cs_n), 32'd0);
    u_if.esp_cs_n = 1'b1;
    tick(3);

    // 3: ESP activity at guard count 10 aborts the handover
    u_if.int_req = 1'b1;
    tick(11);
    u_if.esp_cs_n = 1'b0;
    tick(10);
    check_eq("gin_abort_gnt", 32'(u_if.int_gnt), 32'd0);
    check_eq("gin_abort_owner", 32'(u_if.owner), 32'd0);
    check_eq("gin_abort_col", 32'(u_if.esp_collision), 32'd0);
    u_if.esp_cs_n = 1'b1;
    tick(GUARD + SYNC);
    check_eq("regnt_early", 32'(u_if.int_gnt), 32'd0);
    tick(1);
    check_eq("regnt_on", 32'(u_if.int_gnt), 32'd1);
    check_eq("regnt_col", 32'(u_if.esp_collision), 32'd0);

`ifdef SPI_ARB_INT_TIMEOUT_EN
    // 6: ownership timeout forces revoke
    tick(TMAX - 1);
    check_eq("to_before_gnt", 32'(u_if.int_gnt), 32'd1);
    check_eq("to_before_abort", 32'(u_if.int_abort), 32'd0);
    tick(1);
    check_eq("to_abort", 32'(u_if.int_abort), 32'd1);
    check_eq("to_gnt", 32'(u_if.int_gnt), 32'd0);
    check_eq("to_owner", 32'(u_if.owner), 32'd1);
    tick(1);
    check_eq("to_abort_pulse", 32'(u_if.int_abort), 32'd0);
    tick(GUARD + 20);
    check_eq("to_no_regnt", 32'(u_if.int_gnt), 32'd0);
    check_eq("to_idle", 32'(u_if.owner), 32'd0);
    u_if.int_req = 1'b0;
    tick(1);
    u_if.int_req = 1'b1;
    tick(GUARD);
    check_eq("to_regnt_early", 32'(u_if.int_gnt), 32'd0);
    tick(1);
    check_eq("to_regnt", 32'(u_if.int_gnt), 32'd1);
`endif

    u_if.int_req = 1'b0;
    tick(GUARD + 3);
    check_eq("end_owner", 32'(u_if.owner), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
